// File: rtl/oserdes_edge_generator.sv
// Square-wave word generator for an 8:1 serializer: emits one 8-bit parallel word per CLK,
// toggling the level every H bit times, with half-period updates taken only at rising toggles.
module oserdes_edge_generator #(
    parameter logic [15:0] DEFAULT_HALF_PERIOD = 16'd64
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        ENABLE,
    input  logic [15:0] HALF_PERIOD,
    input  logic        PERIOD_VALID,
    output logic        PERIOD_READY,
    output logic [7:0]  OUT,
    output logic        EDGE_FLAG,
    output logic [2:0]  EDGE_BIT
);

    logic        level_q, level_d;
    logic [16:0] rem_q, rem_d;
    logic [15:0] half_q, half_d;
    logic [15:0] pend_val_q, pend_val_d;
    logic        pend_q, pend_d;
    logic        ready_q, ready_d;
    logic [7:0]  out_q, out_d;
    logic        flag_q, flag_d;
    logic [2:0]  ebit_q, ebit_d;

    logic        accept;
    logic [15:0] clamped;
    logic [15:0] step;
    logic [7:0]  mask;

    assign accept  = PERIOD_VALID & ready_q;
    assign clamped = (HALF_PERIOD < 16'd8) ? 16'd8 : HALF_PERIOD;

    always_comb begin
        level_d    = level_q;
        rem_d      = rem_q;
        half_d     = half_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        out_d      = 8'h00;
        flag_d     = 1'b0;
        ebit_d     = 3'd0;
        step       = half_q;
        mask       = 8'hFF << rem_q[2:0];

        if (!ENABLE) begin
            // A high level being cut off shows up as a falling edge at bit 0.
            flag_d  = level_q;
            level_d = 1'b0;
            rem_d   = 17'd0;
            if (pend_q) begin
                half_d = pend_val_q;
                pend_d = 1'b0;
            end
        end else if (rem_q < 17'd8) begin
            out_d   = level_q ? ~mask : mask;
            flag_d  = 1'b1;
            ebit_d  = rem_q[2:0];
            level_d = ~level_q;
            // Pending period only takes effect on a rising toggle so each high/low pair is consistent.
            if (!level_q && pend_q) begin
                half_d = pend_val_q;
                pend_d = 1'b0;
                step   = pend_val_q;
            end
            rem_d = rem_q + {1'b0, step} - 17'd8;
        end else begin
            out_d = {8{level_q}};
            rem_d = rem_q - 17'd8;
        end

        // Acceptance needs ready, which implies nothing was pending, so it never races an apply.
        if (accept) begin
            pend_val_d = clamped;
            pend_d     = 1'b1;
        end
        ready_d = !accept && !pend_q;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            level_q    <= 1'b0;
            rem_q      <= 17'd0;
            half_q     <= DEFAULT_HALF_PERIOD;
            pend_val_q <= 16'd0;
            pend_q     <= 1'b0;
            ready_q    <= 1'b0;
            out_q      <= 8'h00;
            flag_q     <= 1'b0;
            ebit_q     <= 3'd0;
        end else begin
            level_q    <= level_d;
            rem_q      <= rem_d;
            half_q     <= half_d;
            pend_val_q <= pend_val_d;
            pend_q     <= pend_d;
            ready_q    <= ready_d;
            out_q      <= out_d;
            flag_q     <= flag_d;
            ebit_q     <= ebit_d;
        end
    end

    assign PERIOD_READY = ready_q;
    assign OUT          = out_q;
    assign EDGE_FLAG    = flag_q;
    assign EDGE_BIT     = ebit_q;

endmodule
